// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor: WIDTH bits resolved SEG bits per stage,
// with an elastic valid/ready pipeline and signed-overflow detection on the output register.
module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = SEG / 4;

    logic [STAGES-1:0] valid_q, valid_d, adv, load;
    logic [WIDTH-1:0]  bEff;
    logic              c0;
    logic              accept;

    // One segment: 4-bit CLA groups whose carries-in come from group-level look-ahead.
    function automatic logic [SEG:0] claSeg(input logic [SEG-1:0] a,
                                            input logic [SEG-1:0] b,
                                            input logic           cin);
        logic [SEG-1:0]  g, p, s;
        logic [NGRP-1:0] gg, gp;
        logic [NGRP:0]   gc;
        logic [3:0]      c;
        logic            acc, pp;
        int              base;
        g  = a & b;
        p  = a ^ b;
        s  = '0;
        for (int j = 0; j < NGRP; j++) begin
            base  = 4 * j;
            gg[j] = g[base+3] | (p[base+3] & g[base+2]) | (p[base+3] & p[base+2] & g[base+1])
                  | (p[base+3] & p[base+2] & p[base+1] & g[base]);
            gp[j] = &p[base +: 4];
        end
        gc[0] = cin;
        for (int j = 0; j < NGRP; j++) begin
            acc = gg[j];
            pp  = gp[j];
            for (int i = j - 1; i >= 0; i--) begin
                acc = acc | (pp & gg[i]);
                pp  = pp & gp[i];
            end
            gc[j+1] = acc | (pp & cin);
        end
        for (int j = 0; j < NGRP; j++) begin
            base = 4 * j;
            c[0] = gc[j];
            c[1] = g[base] | (p[base] & c[0]);
            c[2] = g[base+1] | (p[base+1] & g[base]) | (p[base+1] & p[base] & c[0]);
            c[3] = g[base+2] | (p[base+2] & g[base+1]) | (p[base+2] & p[base+1] & g[base])
                 | (p[base+2] & p[base+1] & p[base] & c[0]);
            s[base +: 4] = p[base +: 4] ^ c;
        end
        return {gc[NGRP], s};
    endfunction

    assign bEff = sub_i ? ~b_i : b_i;
    assign c0   = sub_i | cin_i;

    // Drain decisions ripple back from the output so a full pipe can accept while draining.
    always_comb begin
        adv           = '0;
        adv[STAGES-1] = valid_q[STAGES-1] && ready_i;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = valid_q[k] && (!valid_q[k+1] || adv[k+1]);
        end
    end

    assign ready_o = (!valid_q[0] || adv[0]) && rst_ni;
    assign accept  = valid_i && ready_o;

    always_comb begin
        load    = '0;
        valid_d = valid_q;
        load[0] = accept;
        for (int k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            valid_d[k] = load[k] | (valid_q[k] & ~adv[k]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : gStage
        localparam int REM = WIDTH - (k + 1) * SEG;

        logic [WIDTH-k*SEG-1:0] opA, opB;
        logic                   segCin;
        logic [SEG:0]           segRes;
        logic [(k+1)*SEG-1:0]   sum_d, sum_q;
        logic                   carry_q;

        // opA/opB hold the operand bits not yet resolved, current segment at the bottom.
        if (k == 0) begin : gIn
            assign opA    = a_i;
            assign opB    = bEff;
            assign segCin = c0;
            assign sum_d  = segRes[SEG-1:0];
        end else begin : gIn
            assign opA    = gStage[k-1].gRem.aRem_q;
            assign opB    = gStage[k-1].gRem.bRem_q;
            assign segCin = gStage[k-1].carry_q;
            assign sum_d  = {segRes[SEG-1:0], gStage[k-1].sum_q};
        end

        assign segRes = claSeg(opA[SEG-1:0], opB[SEG-1:0], segCin);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (load[k]) begin
                sum_q   <= sum_d;
                carry_q <= segRes[SEG];
            end
        end

        if (k < STAGES - 1) begin : gRem
            logic [REM-1:0] aRem_q, bRem_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    aRem_q <= '0;
                    bRem_q <= '0;
                end else if (load[k]) begin
                    aRem_q <= opA[WIDTH-k*SEG-1:SEG];
                    bRem_q <= opB[WIDTH-k*SEG-1:SEG];
                end
            end
        end else begin : gOut
            logic ovf_d, ovf_q;

            // The last segment still holds A[MSB] and B'[MSB], so overflow is decided here.
            assign ovf_d = (opA[SEG-1] == opB[SEG-1]) && (segRes[SEG-1] != opA[SEG-1]);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    ovf_q <= 1'b0;
                end else if (load[k]) begin
                    ovf_q <= ovf_d;
                end
            end

            assign sum_o  = sum_q;
            assign cout_o = carry_q;
            assign ovf_o  = ovf_q;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: directed corner cases, back-pressure,
// mid-stream reset and a randomised valid/ready stream.
module tb_pipelined_cla_adder;
    localparam int     WIDTH  = 32;
    localparam int     STAGES = 4;
    localparam longint SMAX   = 64'sd2147483647;
    localparam longint SMIN   = -64'sd2147483648;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk, rstN, validIn, readyOut, readyIn, cinIn, subIn;
    logic             validOut, coutOut, ovfOut;
    logic [WIDTH-1:0] aIn, bIn, sumOut;

    int   assertions = 0;
    int   failures   = 0;
    exp_t sbQ[$];

    pipelined_cla_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk_i   (clk),
        .rst_ni  (rstN),
        .valid_i (validIn),
        .ready_o (readyOut),
        .a_i     (aIn),
        .b_i     (bIn),
        .cin_i   (cinIn),
        .sub_i   (subIn),
        .valid_o (validOut),
        .ready_i (readyIn),
        .sum_o   (sumOut),
        .cout_o  (coutOut),
        .ovf_o   (ovfOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden result: plain wide addition, overflow judged by signed range.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        exp_t             e;
        logic [WIDTH-1:0] bb;
        logic             c;
        logic [WIDTH:0]   full;
        longint           sres;
        bb     = sub ? ~b : b;
        c      = sub ? 1'b1 : cin;
        full   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c};
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        sres   = longint'($signed(a)) + longint'($signed(bb)) + longint'(c);
        e.ovf  = (sres > SMAX) || (sres < SMIN);
        return e;
    endfunction

    // Drive one cycle of inputs at the falling edge, then let ready_o settle.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic c,
                                 input logic s, input logic r);
        @(negedge clk);
        validIn = v;
        aIn     = a;
        bIn     = b;
        cinIn   = c;
        subIn   = s;
        readyIn = r;
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        applyStimulus(1'b1, 32'hDEADBEEF, 32'h1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hDEADBEEF, 32'h1, 1'b1, 1'b0, 1'b1);
        assertions++;
        if (validOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_valid: got %b, want 0", validOut);
        end
        assertions++;
        if (readyOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %b, want 0", readyOut);
        end
        assertions++;
        if ({sumOut, coutOut, ovfOut} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data: got sum=%h cout=%b ovf=%b, want all 0", sumOut, coutOut, ovfOut);
        end
        @(negedge clk);
        validIn = 1'b0;
        rstN    = 1'b1;
        #1;
        assertions++;
        if (readyOut !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release_ready: got %b, want 1", readyOut);
        end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] tA[6]    = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'h80000000, 32'h12345678, 32'h0000000F};
        logic [WIDTH-1:0] tB[6]    = '{32'h00000000, 32'h00000001, 32'd7, 32'h00000001, 32'h12345678, 32'h00000001};
        logic             tC[6]    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic             tS[6]    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [WIDTH-1:0] tSum[6]  = '{32'h00000000, 32'h80000000, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h00000000, 32'h00000011};
        logic             tCout[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic             tOvf[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_t             e;
        int               lat;
        bit               got;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, tA[i], tB[i], tC[i], tS[i], 1'b1);
            assertions++;
            if (readyOut !== 1'b1) begin
                failures++;
                $display("[TB] FAIL directed_accept[%0d]: ready_o=%b, want 1", i, readyOut);
            end else begin
                sbQ.push_back('{sum: tSum[i], cout: tCout[i], ovf: tOvf[i]});
            end
            lat = 0;
            got = 0;
            while (!got && lat < 10) begin
                applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
                lat++;
                if (validOut) begin
                    got = 1;
                    assertions++;
                    if (sbQ.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL directed_result[%0d]: unexpected sum=%h, want none", i, sumOut);
                    end else begin
                        e = sbQ.pop_front();
                        if ({sumOut, coutOut, ovfOut} !== {e.sum, e.cout, e.ovf}) begin
                            failures++;
                            $display("[TB] FAIL directed_result[%0d]: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                                     i, sumOut, coutOut, ovfOut, e.sum, e.cout, e.ovf);
                        end
                    end
                end
            end
            assertions++;
            if (!got || lat != STAGES) begin
                failures++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d samples (seen=%0d), want %0d", i, lat, got, STAGES);
            end
        end
    endtask

    task automatic test_back_to_back();
        int               next = 0;
        int               acc  = 0;
        int               got  = 0;
        bit               held = 0;
        logic [WIDTH+1:0] heldVal = '0;
        logic             rdy;
        exp_t             e;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            rdy = !(cyc >= 2 && cyc <= 6);
            applyStimulus(next < 8, WIDTH'(next), WIDTH'(next) << 28, 1'b0, 1'b0, rdy);
            if (cyc < 4) begin
                assertions++;
                if (readyOut !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL bp_ready_early: cycle %0d ready_o=%b, want 1", cyc, readyOut);
                end
            end
            if (cyc == 4) begin
                assertions++;
                if (readyOut !== 1'b0 || acc != STAGES) begin
                    failures++;
                    $display("[TB] FAIL bp_full: ready_o=%b accepts=%0d, want 0 and %0d", readyOut, acc, STAGES);
                end
            end
            if (cyc == 7) begin
                assertions++;
                if (readyOut !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL bp_release_ready: got %b, want 1", readyOut);
                end
            end
            if (held) begin
                assertions++;
                if (validOut !== 1'b1 || {sumOut, coutOut, ovfOut} !== heldVal) begin
                    failures++;
                    $display("[TB] FAIL bp_hold: got valid=%b out=%h, want 1 and %h", validOut, {sumOut, coutOut, ovfOut}, heldVal);
                end
            end
            held    = validOut && !readyIn;
            heldVal = {sumOut, coutOut, ovfOut};
            if (validIn && readyOut) begin
                sbQ.push_back(model(aIn, bIn, cinIn, subIn));
                next++;
                acc++;
            end
            if (validOut && readyIn) begin
                assertions++;
                got++;
                if (sbQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL bp_result: unexpected sum=%h, want none", sumOut);
                end else begin
                    e = sbQ.pop_front();
                    if ({sumOut, coutOut, ovfOut} !== {e.sum, e.cout, e.ovf}) begin
                        failures++;
                        $display("[TB] FAIL bp_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                                 sumOut, coutOut, ovfOut, e.sum, e.cout, e.ovf);
                    end
                end
            end
        end
        assertions++;
        if (got != 8 || sbQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL bp_count: got %0d results with %0d pending, want 8 and 0", got, sbQ.size());
        end
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        int   lat;
        bit   got;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h11111111 * (i + 1), 32'h22222222, 1'b0, 1'b0, 1'b0);
            if (validIn && readyOut) sbQ.push_back(model(aIn, bIn, cinIn, subIn));
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        assertions++;
        if (validOut !== 1'b1 || sumOut !== 32'h33333333) begin
            failures++;
            $display("[TB] FAIL mid_pre_reset: got valid=%b sum=%h, want 1 and 33333333", validOut, sumOut);
        end
        #2 rstN = 1'b0;
        #1;
        assertions++;
        if (validOut !== 1'b0 || sumOut !== '0 || readyOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset_async: got valid=%b sum=%h ready=%b, want 0 0 0", validOut, sumOut, readyOut);
        end
        sbQ.delete();
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            assertions++;
            if (validOut !== 1'b0) begin
                failures++;
                $display("[TB] FAIL mid_stale: cycle %0d valid_o=%b, want 0", i, validOut);
            end
        end
        applyStimulus(1'b1, 32'h89ABCDEF, 32'h12345678, 1'b1, 1'b0, 1'b1);
        if (validIn && readyOut) sbQ.push_back(model(aIn, bIn, cinIn, subIn));
        lat = 0;
        got = 0;
        while (!got && lat < 10) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            lat++;
            if (validOut) begin
                got = 1;
                assertions++;
                if (sbQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL mid_new_result: unexpected sum=%h, want none", sumOut);
                end else begin
                    e = sbQ.pop_front();
                    if ({sumOut, coutOut, ovfOut} !== {e.sum, e.cout, e.ovf}) begin
                        failures++;
                        $display("[TB] FAIL mid_new_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                                 sumOut, coutOut, ovfOut, e.sum, e.cout, e.ovf);
                    end
                end
            end
        end
        assertions++;
        if (!got || lat != STAGES) begin
            failures++;
            $display("[TB] FAIL mid_new_latency: got %0d samples (seen=%0d), want %0d", lat, got, STAGES);
        end
    endtask

    task automatic test_random();
        int               acc  = 0;
        bit               held = 0;
        logic [WIDTH+1:0] heldVal = '0;
        logic [WIDTH-1:0] a, b;
        logic             v, r, c, s;
        exp_t             e;
        for (int cyc = 0; cyc < 60000 && acc < 10000; cyc++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            a = $urandom;
            b = $urandom;
            c = $urandom_range(0, 1);
            s = $urandom_range(0, 1);
            case ($urandom_range(0, 7))
                0: a = '1;
                1: b = '1;
                2: a = 32'h80000000;
                3: b = 32'h7FFFFFFF;
                default: ;
            endcase
            applyStimulus(v, a, b, c, s, r);
            if (held) begin
                assertions++;
                if (validOut !== 1'b1 || {sumOut, coutOut, ovfOut} !== heldVal) begin
                    failures++;
                    $display("[TB] FAIL rand_hold: got valid=%b out=%h, want 1 and %h", validOut, {sumOut, coutOut, ovfOut}, heldVal);
                end
            end
            held    = validOut && !readyIn;
            heldVal = {sumOut, coutOut, ovfOut};
            if (validIn && readyOut) begin
                sbQ.push_back(model(aIn, bIn, cinIn, subIn));
                acc++;
            end
            if (validOut && readyIn) begin
                assertions++;
                if (sbQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL rand_result: unexpected sum=%h, want none", sumOut);
                end else begin
                    e = sbQ.pop_front();
                    if ({sumOut, coutOut, ovfOut} !== {e.sum, e.cout, e.ovf}) begin
                        failures++;
                        $display("[TB] FAIL rand_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                                 sumOut, coutOut, ovfOut, e.sum, e.cout, e.ovf);
                    end
                end
            end
        end
        for (int i = 0; i < 20 && sbQ.size() > 0; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            if (validOut) begin
                assertions++;
                e = sbQ.pop_front();
                if ({sumOut, coutOut, ovfOut} !== {e.sum, e.cout, e.ovf}) begin
                    failures++;
                    $display("[TB] FAIL rand_drain: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                             sumOut, coutOut, ovfOut, e.sum, e.cout, e.ovf);
                end
            end
        end
        assertions++;
        if (acc != 10000 || sbQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL rand_count: accepted %0d with %0d pending, want 10000 and 0", acc, sbQ.size());
        end
    endtask

    initial begin
        rstN    = 1'b0;
        validIn = 1'b0;
        readyIn = 1'b0;
        aIn     = '0;
        bIn     = '0;
        cinIn   = 1'b0;
        subIn   = 1'b0;
        $display("[TB] starting pipelined_cla_adder bench");
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-look-ahead adder/subtractor for the ASIC adder-comparison suite. It extends the combinational 4-bit CLA cell to a WIDTH-bit datapath split into STAGES carry-registered segments. Each segment is built from 4-bit CLA groups. The block provides a valid/ready handshake with full back-pressure, an add/subtract mode, and signed-overflow detection. It sits between operand-source and result-sink logic as a throughput-1 arithmetic unit.

## Interface
- WIDTH, 32: operand/result width. Must be a multiple of 4·STAGES.
- STAGES, 4: number of pipeline segments. SEG = WIDTH/STAGES bits are resolved per stage.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_i  in  1  input operands valid.
- ready_o  out  1  block can accept an operand this cycle.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- cin_i  in  1  carry-in. Used only when sub_i=0.
- sub_i  in  1  0: A+B+cin_i; 1: A−B.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- sum_o  out  WIDTH  result.
- cout_o  out  1  carry out of MSB. In subtract mode, 1 means no borrow.
- ovf_o  out  1  two's-complement signed overflow.

## Operation
- **Effective operands:** B' = sub_i ? ~b_i : b_i. c0 = sub_i ? 1 : cin_i. All mode decisions are taken at accept time.
- **Segment datapath:** stage k (0..STAGES−1) computes bits [k·SEG +: SEG] of A+B'+carry_in_k. It uses SEG/4 4-bit CLA groups chained through group-level look-ahead, so there is no ripple inside a group.
  - carry_in_0 = c0.
  - carry_in_k = the carry registered by stage k−1.
- **Stage k register contents:**
  - valid bit.
  - Resolved sum bits [0 .. (k+1)·SEG−1].
  - Unresolved A and B' bits above the segment.
  - Segment carry-out.
  - A[MSB] and B'[MSB], carried for overflow.
- **Output register:** the final stage register is the output register. sum_o is the full sum, cout_o is the final carry, and ovf_o = (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB]).
- **Handshake:** elastic pipeline.
  - adv_k = valid_q[k] && (k==STAGES−1 ? ready_i : (!valid_q[k+1] || adv_{k+1})).
  - Stage k loads when its upstream offers data and (!valid_q[k] || adv_k).
  - ready_o = (!valid_q[0] || adv_0) && rst_ni.
  - Accept occurs when valid_i && ready_o.
  - A stage that neither loads nor drains holds its contents.
- **Output stability:** while valid_o && !ready_i, sum_o, cout_o and ovf_o are held bit-stable.
- **Ordering:** results emerge strictly in acceptance order. Nothing is dropped or duplicated.

## Timing
- **Reset (rst_ni low):**
  - All valid bits clear immediately (asynchronous).
  - All data registers, sum_o, cout_o and ovf_o are 0.
  - valid_o=0 and ready_o=0.
  - First accept is possible in the first cycle after rst_ni deasserts.
- **Latency:** an operand accepted at edge N appears with valid_o=1 after edge N+STAGES−1, i.e. STAGES cycles including the accept cycle, when there is no stall.
- **Throughput:** 1 result per cycle while ready_i=1.
- **Capacity:** the pipeline holds STAGES operands.
  - With ready_i=0 held, ready_o falls once every stage is valid (after STAGES accepts).
  - When full and ready_i rises, ready_o is 1 in the same cycle: accept and drain happen simultaneously.
- **Reset mid-operation:** in-flight results are discarded. No valid_o pulse is produced for them after reset releases.
- **Combinational path:** ready_i reaches ready_o combinationally through the adv chain. No combinational path exists from a_i/b_i/valid_i to any output.

## Test plan
Checks below use WIDTH=32, STAGES=4.
- **Carry through all stages:** a=0xFFFFFFFF, b=0, cin=1, sub=0 -> sum=0x00000000, cout=1, ovf=0; valid_o is 1 exactly 3 edges after the accept edge.
- **Signed overflow, add:** a=0x7FFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x80000000, cout=0, ovf=1.
- **Subtract with borrow:** a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0. Then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- **Back-pressure:** stream 8 operands (a=i, b=i<<28) with ready_i=0 for cycles 2–6.
  - ready_o drops after 4 accepts.
  - Outputs are held stable while stalled.
  - All 8 results arrive in order with correct values; none are lost or duplicated.
- **Reset mid-stream:** assert rst_ni low asynchronously mid-cycle with 3 operands in flight.
  - valid_o, sum_o and ready_o go to 0 immediately.
  - After release, no stale result appears.
  - A new operand produces a correct result 4 cycles after its accept.
- **Randomised scoreboard:** 10k random a, b, cin and sub values with random valid_i/ready_i. Compare every result against a golden {cout, sum} = A+B'+c0 and the overflow formula; expect zero mismatches.
